// File: rtl/uart_sampler_pkg.sv
// Shared constants and helpers for the oversampling bit voter.
// Legal oversampling ratios, default vote width and sample-window placement.
package uart_sampler_pkg;

    localparam int PRESCALE_8      = 8;
    localparam int PRESCALE_16     = 16;
    localparam int PRESCALE_32     = 32;
    localparam int DEF_NUM_SAMPLES = 3;

    // Index of the first voted sample, centred on ratio/2.
    function automatic int first_sample_idx(input int ratio, input int num_samples);
        return (ratio >> 1) - (num_samples - 1) / 2;
    endfunction

    function automatic logic ratio_legal(input int ratio, input int num_samples);
        return ((ratio == PRESCALE_8) || (ratio == PRESCALE_16) || (ratio == PRESCALE_32))
               && (ratio >= 2 * num_samples);
    endfunction

endpackage

// File: rtl/majority_vote.sv
// Combinational majority of an odd number of samples (popcount compare).
module majority_vote #(
    parameter int NUM_SAMPLES = 3
) (
    input  logic [NUM_SAMPLES-1:0] samples,
    output logic                   majority
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    logic [CNT_W-1:0] ones;

    always_comb begin
        ones = '0;
        for (int i = 0; i < NUM_SAMPLES; i++)
            ones = ones + {{(CNT_W-1){1'b0}}, samples[i]};
    end

    assign majority = (int'(ones) > NUM_SAMPLES / 2);

endmodule

// File: rtl/oversample_voter.sv
// Oversampling UART bit voter: counts edges per bit, captures centre samples, votes.
// Define OVERSAMPLE_NOISE_DETECT_EN to enable the noise_flag (non-unanimous samples) output.
module oversample_voter
    import uart_sampler_pkg::*;
#(
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int PRESCALE_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  dat_sample_en,
    input  logic                  RX_IN,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  noise_flag,
    output logic                  cfg_err
);

    logic                   en_d;
    logic [PRESCALE_W-1:0]  ratio;
    logic [NUM_SAMPLES-1:0] samples;
    logic                   en_rise, eff_err, in_window, bit_end, bit_done, vote;
    logic [PRESCALE_W-1:0]  eff_ratio, first_idx, last_idx;

    // On the rising cycle the new prescale is not yet in ratio, so use it directly.
    assign en_rise   = dat_sample_en & ~en_d;
    assign eff_ratio = en_rise ? prescale : ratio;
    assign eff_err   = en_rise ? ~ratio_legal(int'(prescale), NUM_SAMPLES) : cfg_err;
    assign first_idx = PRESCALE_W'(first_sample_idx(int'(eff_ratio), NUM_SAMPLES));
    assign last_idx  = first_idx + PRESCALE_W'(NUM_SAMPLES - 1);
    assign in_window = (edge_cnt >= first_idx) && (edge_cnt <= last_idx);
    assign bit_end   = (edge_cnt == eff_ratio - PRESCALE_W'(1));
    assign bit_done  = dat_sample_en & bit_end & ~eff_err;

    majority_vote #(.NUM_SAMPLES(NUM_SAMPLES)) u_vote (
        .samples  (samples),
        .majority (vote)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_d         <= 1'b0;
            ratio        <= PRESCALE_W'(PRESCALE_8);
            cfg_err      <= 1'b0;
            edge_cnt     <= '0;
            samples      <= '0;
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            en_d         <= dat_sample_en;
            sample_valid <= 1'b0;
            if (!dat_sample_en) begin
                edge_cnt <= '0;
                samples  <= '0;
            end else begin
                if (en_rise) begin
                    ratio   <= prescale;
                    cfg_err <= eff_err;
                end
                if (in_window && !eff_err)
                    samples <= {samples[NUM_SAMPLES-2:0], RX_IN};
                if (bit_end)
                    edge_cnt <= '0;
                else
                    edge_cnt <= edge_cnt + PRESCALE_W'(1);
                if (bit_done) begin
                    sampled_bit  <= vote;
                    sample_valid <= 1'b1;
                end
            end
        end
    end

`ifdef OVERSAMPLE_NOISE_DETECT_EN
    logic noise_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            noise_q <= 1'b0;
        else if (bit_done)
            noise_q <= (|samples) & ~(&samples);
    end

    assign noise_flag = noise_q;
`else
    assign noise_flag = 1'b0;
`endif

endmodule

// File: tb/tb_oversample_voter.sv
// Bench for oversample_voter: NUM_SAMPLES=3 and =5 instances share stimulus and are
// checked every cycle against a per-bit history model plus directed scenario checks.
module tb_oversample_voter;

`ifdef OVERSAMPLE_NOISE_DETECT_EN
    localparam bit NOISE_EN = 1'b1;
`else
    localparam bit NOISE_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [5:0]      prescale;
    logic            dat_sample_en;
    logic            RX_IN;
    logic [1:0][5:0] ec;
    logic [1:0]      sb, sv, nf, ce;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    oversample_voter #(.NUM_SAMPLES(3), .PRESCALE_W(6)) u_dut3 (
        .clk(clk), .rst(rst), .prescale(prescale), .dat_sample_en(dat_sample_en),
        .RX_IN(RX_IN), .edge_cnt(ec[0]), .sampled_bit(sb[0]), .sample_valid(sv[0]),
        .noise_flag(nf[0]), .cfg_err(ce[0])
    );

    oversample_voter #(.NUM_SAMPLES(5), .PRESCALE_W(6)) u_dut5 (
        .clk(clk), .rst(rst), .prescale(prescale), .dat_sample_en(dat_sample_en),
        .RX_IN(RX_IN), .edge_cnt(ec[1]), .sampled_bit(sb[1]), .sample_valid(sv[1]),
        .noise_flag(nf[1]), .cfg_err(ce[1])
    );

    // Reference model: position within the bit, line history per position, vote at bit end.
    int NS [2] = '{3, 5};
    int m_ratio [2];
    int m_pos   [2];
    bit m_enp   [2];
    bit m_err   [2];
    bit m_bit   [2];
    bit m_noise [2];
    bit m_valid [2];
    bit m_hist  [2][64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
            $error("check %s did not match", tag);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ratio[i] = 8; m_pos[i] = 0; m_enp[i] = 0; m_err[i] = 0;
            m_bit[i] = 1; m_noise[i] = 0; m_valid[i] = 0;
        end
    endtask

    task automatic model_edge();
        int ones, first;
        for (int i = 0; i < 2; i++) begin
            if (!dat_sample_en) begin
                m_pos[i] = 0; m_valid[i] = 0; m_enp[i] = 0;
            end else begin
                if (!m_enp[i]) begin
                    m_ratio[i] = int'(prescale);
                    m_pos[i]   = 0;
                    m_err[i]   = !((m_ratio[i] == 8 || m_ratio[i] == 16 || m_ratio[i] == 32)
                                   && m_ratio[i] >= 2 * NS[i]);
                end
                m_hist[i][m_pos[i]] = RX_IN;
                m_valid[i] = 0;
                if (m_pos[i] == m_ratio[i] - 1) begin
                    if (!m_err[i]) begin
                        ones  = 0;
                        first = m_ratio[i] / 2 - (NS[i] - 1) / 2;
                        for (int k = 0; k < NS[i]; k++) ones += int'(m_hist[i][first + k]);
                        m_bit[i]   = (ones > NS[i] / 2);
                        m_noise[i] = (ones != 0) && (ones != NS[i]);
                        m_valid[i] = 1;
                    end
                    m_pos[i] = 0;
                end else begin
                    m_pos[i]++;
                end
                m_enp[i] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("n%0d_edge_cnt", NS[i]), 32'(ec[i]), m_pos[i]);
            chk($sformatf("n%0d_sampled_bit", NS[i]), 32'(sb[i]), 32'(m_bit[i]));
            chk($sformatf("n%0d_sample_valid", NS[i]), 32'(sv[i]), 32'(m_valid[i]));
            chk($sformatf("n%0d_noise_flag", NS[i]), 32'(nf[i]), 32'(NOISE_EN & m_noise[i]));
            chk($sformatf("n%0d_cfg_err", NS[i]), 32'(ce[i]), 32'(m_err[i]));
        end
    endtask

    task automatic cyc(input bit e, input bit r, input int ps);
        dat_sample_en = e;
        RX_IN         = r;
        prescale      = 6'(ps);
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "bench timed out");
    end

    initial begin
        int pulses, first_cyc, ps, len, idle;
        bit cur, held_bit;
        int pat [5] = '{1, 1, 0, 0, 1};
        int ps_list [8] = '{8, 16, 32, 12, 8, 16, 32, 24};

        // Reset state
        rst = 1'b0; dat_sample_en = 1'b0; RX_IN = 1'b1; prescale = 6'd8;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b1;
        cyc(0, 1, 8);

        // Steady 1 for 16 enabled cycles: two pulses, bit 1, no noise
        pulses = 0;
        for (int i = 0; i < 16; i++) begin cyc(1, 1, 8); pulses += int'(sv[0]); end
        cyc(0, 1, 8); pulses += int'(sv[0]);
        chk("steady1_pulses", pulses, 2);
        chk("steady1_bit", 32'(sb[0]), 1);
        chk("steady1_noise", 32'(nf[0]), 0);

        // Line 0 with a glitch at edge 4: votes 0, flags noise
        for (int i = 0; i < 8; i++) cyc(1, (i == 4), 8);
        chk("glitch_valid", 32'(sv[0]), 1);
        chk("glitch_bit", 32'(sb[0]), 0);
        chk("glitch_noise", 32'(nf[0]), 32'(NOISE_EN));
        cyc(0, 1, 8);

        // Five samples at edges 6..10 = 1,1,0,0,1 with ratio 16
        for (int i = 0; i < 16; i++)
            cyc(1, (i >= 6 && i <= 10) ? pat[i-6][0] : 1'($urandom_range(0, 1)), 16);
        chk("n5_pattern_valid", 32'(sv[1]), 1);
        chk("n5_pattern_bit", 32'(sb[1]), 1);
        chk("n5_pattern_noise", 32'(nf[1]), 32'(NOISE_EN));
        cyc(0, 1, 16);

        // Enable dropped at edge 9: counter clears, no pulse, bit held
        held_bit = m_bit[0];
        pulses = 0;
        for (int i = 0; i < 9; i++) begin cyc(1, 1'($urandom_range(0, 1)), 16); pulses += int'(sv[0]); end
        chk("drop_at9_cnt_before", 32'(ec[0]), 9);
        cyc(0, 1, 16); pulses += int'(sv[0]);
        chk("drop_cnt", 32'(ec[0]), 0);
        chk("drop_no_valid", pulses, 0);
        chk("drop_bit_held", 32'(sb[0]), 32'(held_bit));

        // Illegal prescale 12: error latched, no pulses for 24 cycles
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(1, 1'($urandom_range(0, 1)), 12);
            pulses += int'(sv[0]) + int'(sv[1]);
        end
        chk("bad12_cfg_err", 32'(ce[0]), 1);
        chk("bad12_no_valid", pulses, 0);
        cyc(0, 1, 12);
        cyc(1, 1, 8);
        chk("legal8_clears_err", 32'(ce[0]), 0);
        chk("legal8_small_for_n5", 32'(ce[1]), 1);
        for (int i = 1; i < 8; i++) cyc(1, 1, 8);
        cyc(0, 1, 8);

        // Async reset at edge 5 aborts the bit; new bit's pulse appears in cycle 9
        for (int i = 0; i < 5; i++) cyc(1, 0, 8);
        chk("rst_mid_cnt_before", 32'(ec[0]), 5);
        rst = 1'b0; dat_sample_en = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk); #1;
        rst = 1'b1;
        first_cyc = 0;
        for (int i = 1; i <= 20 && first_cyc == 0; i++) begin
            cyc(1, 0, 8);
            if (sv[0] === 1'b1) first_cyc = i + 1;
        end
        chk("rst_resume_latency", first_cyc, 9);
        cyc(0, 1, 8);

        // Random sessions, including ignored prescale changes while enabled
        cur = 1'b1;
        for (int s = 0; s < 40; s++) begin
            ps  = ps_list[$urandom_range(0, 7)];
            len = $urandom_range(1, 3 * ps);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) cur = ~cur;
                cyc(1, cur, (i > 0 && $urandom_range(0, 7) == 0) ? ps_list[$urandom_range(0, 7)] : ps);
            end
            idle = $urandom_range(1, 3);
            for (int i = 0; i < idle; i++) cyc(0, 1'($urandom_range(0, 1)), ps);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
